// File: rtl/div113_pkg.sv
// Shared constants and types for the divide-by-113 datapath.
// Optional remainder output is enabled with DIV113_REM_EN.
package div113_pkg;

    localparam int DIVISOR = 113;
    localparam int REM_W   = 7;

    typedef logic [REM_W-1:0] rem_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } st_e;

endpackage

// File: rtl/div113_digit_step.sv
// One radix-2^K long-division step by 113: {rem, digit} -> (q digit, rem).
// Restoring compare-subtract; requires rem_i < 113 so the quotient fits K bits.
module div113_digit_step
    import div113_pkg::*;
#(
    parameter int K = 4
) (
    input  rem_t         rem_i,
    input  logic [K-1:0] dig_i,
    output logic [K-1:0] q_o,
    output rem_t         rem_o
);

    localparam int TW = REM_W + K;

    logic [TW-1:0] w_t;

    always_comb begin
        w_t = {rem_i, dig_i};
        q_o = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (w_t >= (TW'(DIVISOR) << i)) begin
                w_t    = w_t - (TW'(DIVISOR) << i);
                q_o[i] = 1'b1;
            end
        end
        rem_o = w_t[REM_W-1:0];
    end

endmodule

// File: rtl/div113_seq.sv
// Digit-serial unsigned divider by 113 with valid/ready handshakes.
// Define DIV113_REM_EN to expose the remainder on out_rem.
module div113_seq
    import div113_pkg::*;
#(
    parameter int DW = 36,
    parameter int K  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef DIV113_REM_EN
    output logic [DW-1:0] out_quot,
    output rem_t          out_rem
`else
    output logic [DW-1:0] out_quot
`endif
);

    localparam int N  = DW / K;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (DW % K != 0) begin : g_bad_dw
        $error("div113_seq: DW must be a multiple of K");
    end
    if (!(K == 1 || K == 2 || K == 3 || K == 4 || K == 6)) begin : g_bad_k
        $error("div113_seq: K must be 1, 2, 3, 4 or 6");
    end

    st_e           r_state;
    st_e           w_next;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_div;
    logic [DW-1:0] r_quot;
    rem_t          r_rem;
    logic [K-1:0]  w_q;
    rem_t          w_rem;
    logic          w_accept;
    logic          w_last;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_cnt == CW'(N - 1));

    div113_digit_step #(
        .K(K)
    ) u_step (
        .rem_i (r_rem),
        .dig_i (r_div[DW-1 -: K]),
        .q_o   (w_q),
        .rem_o (w_rem)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_next = BUSY;
            BUSY:    if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Quotient and remainder only move while BUSY, so DONE holds them stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_div  <= in_data;
            r_quot <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
        end else if (r_state == BUSY) begin
            r_div  <= r_div << K;
            r_quot <= {r_quot[DW-K-1:0], w_q};
            r_rem  <= w_rem;
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    a_rem_range: assert property (
        @(posedge clk) disable iff (!rst_n) r_rem < rem_t'(DIVISOR)
    );

    assign in_ready  = rst_n && (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_quot  = r_quot;
`ifdef DIV113_REM_EN
    assign out_rem   = r_rem;
`endif

endmodule

// File: tb/tb_div113_seq.sv
// Self-checking bench for div113_seq: vector table, corner sequences, random run.
// Remainder checks are active when DIV113_REM_EN is defined.
module tb_div113_seq;

    localparam int DW = 36;
    localparam int K  = 4;
    localparam int N  = DW / K;

    typedef struct {
        logic [DW-1:0] d;
        logic [DW-1:0] q;
        logic [6:0]    r;
    } vec_t;

    typedef struct {
        logic [DW-1:0] q;
        logic [6:0]    r;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_quot;
`ifdef DIV113_REM_EN
    logic [6:0]    out_rem;
`endif

    int   nchk = 0;
    int   nerr = 0;
    exp_t sb[$];
    vec_t vt[5];

    always #5 clk = ~clk;

    div113_seq #(
        .DW(DW),
        .K (K)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DIV113_REM_EN
        .out_quot  (out_quot),
        .out_rem   (out_rem)
`else
        .out_quot  (out_quot)
`endif
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [DW-1:0] d);
        exp_t e;
        longint unsigned x;
        x   = 64'(d);
        e.q = DW'(x / 113);
        e.r = 7'(x % 113);
        return e;
    endfunction

    task automatic run_div(input logic [DW-1:0] d, input exp_t e_in,
                           input int hold);
        int            n;
        exp_t          e;
        logic [DW-1:0] q0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        sb.push_back(e_in);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("in_ready_busy", 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'(N));
        q0 = out_quot;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = ~d;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_quot", 64'(out_quot), 64'(q0));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check("quot", 64'(out_quot), 64'(e.q));
`ifdef DIV113_REM_EN
            check("rem", 64'(out_rem), 64'(e.r));
            check("rem_lt_113", 64'(out_rem < 7'd113), 64'd1);
`endif
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("ready_back", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [DW-1:0] d;
        exp_t          e;

        vt[0] = '{d: 36'd0,           q: 36'd0,         r: 7'd0};
        vt[1] = '{d: 36'd112,         q: 36'd0,         r: 7'd112};
        vt[2] = '{d: 36'd113,         q: 36'd1,         r: 7'd0};
        vt[3] = '{d: 36'd12345,       q: 36'd109,       r: 7'd28};
        vt[4] = '{d: 36'd68719476735, q: 36'd608136962, r: 7'd29};

        #2;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_quot", 64'(out_quot), 64'd0);
`ifdef DIV113_REM_EN
        check("rst_out_rem", 64'(out_rem), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 5; i++) begin
            e.q = vt[i].q;
            e.r = vt[i].r;
            run_div(vt[i].d, e, 0);
        end

        e = model(36'd999999);
        run_div(36'd999999, e, 20);

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 36'd1000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_quot", 64'(out_quot), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
`ifdef DIV113_REM_EN
        check("midrst_rem", 64'(out_rem), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        e.q = 36'd2;
        e.r = 7'd0;
        run_div(36'd226, e, 0);

        for (int i = 0; i < 1500; i++) begin
            d = DW'({$urandom(), $urandom()});
            if (i % 7 == 0) d = DW'($urandom_range(0, 500));
            e = model(d);
            run_div(d, e, int'($urandom_range(0, 2)));
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0 want 1");
        $fatal(1, "timeout");
    end

endmodule
